pc_sequencer_mc: RTL

Multi-context program-counter sequencer: the parametrised successor of the single-thread PC incrementor. It holds one word-address PC per hardware context and issues one byte-addressed fetch PC per enabled cycle, picking among active contexts round-robin. It supports jump/call/return redirects with a per-context return-address stack (RAS), plus context start/halt. It sits between the core control unit and the instruction memory in each processor core.

---
 rtl/arya_pc_pkg.sv | 24 ++
 rtl/pc_ras.sv | 59 +++++
 rtl/pc_sequencer_mc.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arya_pc_pkg.sv
// Shared definitions for the multi-context PC sequencer: redirect encodings
// and a constant clog2 helper for sizing context/stack indices.
package arya_pc_pkg;

   typedef enum logic [1:0] {
      RD_JUMP = 2'b00,
      RD_CALL = 2'b01,
      RD_RET  = 2'b10,
      RD_ALT  = 2'b11
   } redirect_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Single-context circular return-address stack. A push onto a full stack
// overwrites the oldest entry; strobes flag overflow and empty pops.
module pc_ras
   import arya_pc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int PTR_W = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W:0]   count;
   logic             full;

   assign top_idx   = wr_ptr - PTR_W'(1);
   assign top_data  = mem[top_idx];
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);
   assign overflow  = push & full & ~clear;
   assign underflow = pop & empty & ~clear & ~push;

   // The write pointer wraps naturally; count saturates so the oldest entry is lost
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         mem[wr_ptr] <= push_data;
         wr_ptr      <= wr_ptr + PTR_W'(1);
         if (!full) begin
            count <= count + (PTR_W+1)'(1);
         end
      end else if (pop && !empty) begin
         wr_ptr <= top_idx;
         count  <= count - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer_mc.sv
// Multi-context PC sequencer: round-robin issue of byte-addressed fetch PCs
// with per-context jump/call/return redirects, start and halt.
module pc_sequencer_mc
   import arya_pc_pkg::*;
#(
   parameter  int INST_ADDR_WIDTH = 8,
   parameter  int NUM_CTX         = 4,
   parameter  int RAS_DEPTH       = 4,
   localparam int CTX_W           = clog2(NUM_CTX)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       en,
   input  logic                       ctx_start,
   input  logic [CTX_W-1:0]           start_ctx,
   input  logic [INST_ADDR_WIDTH-1:0] start_pc,
   input  logic                       ctx_halt,
   input  logic [CTX_W-1:0]           halt_ctx,
   input  logic                       redirect,
   input  logic [CTX_W-1:0]           redirect_ctx,
   input  logic [1:0]                 redirect_type,
   input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
   input  logic [INST_ADDR_WIDTH-1:0] redirect_link,
   output logic                       pc_valid,
   output logic [CTX_W-1:0]           pc_ctx,
   output logic [INST_ADDR_WIDTH+1:0] pc_out,
   output logic [NUM_CTX-1:0]         ctx_active,
   output logic                       ras_overflow,
   output logic                       ras_underflow
);

   localparam int AW = INST_ADDR_WIDTH;

   logic [AW-1:0]      pc_q    [NUM_CTX];
   logic [AW-1:0]      pc_next [NUM_CTX];
   logic [AW-1:0]      ras_top [NUM_CTX];
   logic [NUM_CTX-1:0] active_next;
   logic [NUM_CTX-1:0] push_vec;
   logic [NUM_CTX-1:0] pop_vec;
   logic [NUM_CTX-1:0] clear_vec;
   logic [NUM_CTX-1:0] ras_empty;
   logic [NUM_CTX-1:0] ras_ovf;
   logic [NUM_CTX-1:0] ras_unf;
   logic [CTX_W-1:0]   rr_last;
   logic [CTX_W-1:0]   sel;
   logic [CTX_W-1:0]   cand;
   logic               found;
   logic               issue;

   // Search starts just after the last issued context and wraps; offset NUM_CTX lands back on it
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_CTX; i++) begin
         cand = rr_last + CTX_W'(i);
         if (!found && ctx_active[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign issue = en & found;

   always_comb begin
      active_next = ctx_active;
      push_vec    = '0;
      pop_vec     = '0;
      clear_vec   = '0;
      for (int c = 0; c < NUM_CTX; c++) begin
         pc_next[c] = pc_q[c];
         if (ctx_start && start_ctx == CTX_W'(c)) begin
            pc_next[c]     = start_pc;
            clear_vec[c]   = 1'b1;
            active_next[c] = 1'b1;
         end else if (ctx_halt && halt_ctx == CTX_W'(c)) begin
            active_next[c] = 1'b0;
         end else if (redirect && redirect_ctx == CTX_W'(c) && ctx_active[c]) begin
            case (redirect_e'(redirect_type))
               RD_CALL: begin
                  pc_next[c]  = redirect_pc;
                  push_vec[c] = 1'b1;
               end
               RD_RET: begin
                  pop_vec[c] = 1'b1;
                  pc_next[c] = ras_empty[c] ? redirect_pc : ras_top[c];
               end
               default: pc_next[c] = redirect_pc;
            endcase
         end else if (issue && sel == CTX_W'(c)) begin
            pc_next[c] = pc_q[c] + AW'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_CTX; g++) begin : g_ras
      pc_ras #(
         .DEPTH (RAS_DEPTH),
         .WIDTH (AW)
      ) u_ras (
         .clk       (clk),
         .reset_n   (reset_n),
         .clear     (clear_vec[g]),
         .push      (push_vec[g]),
         .pop       (pop_vec[g]),
         .push_data (redirect_link),
         .top_data  (ras_top[g]),
         .empty     (ras_empty[g]),
         .overflow  (ras_ovf[g]),
         .underflow (ras_unf[g])
      );
   end

   // pc_out/pc_ctx hold across stalls; only pc_valid drops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CTX; c++) begin
            pc_q[c] <= '0;
         end
         ctx_active    <= {{(NUM_CTX-1){1'b0}}, 1'b1};
         rr_last       <= CTX_W'(NUM_CTX - 1);
         pc_valid      <= 1'b0;
         pc_ctx        <= '0;
         pc_out        <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CTX; c++) begin
            pc_q[c] <= pc_next[c];
         end
         ctx_active    <= active_next;
         pc_valid      <= issue;
         ras_overflow  <= |ras_ovf;
         ras_underflow <= |ras_unf;
         if (issue) begin
            rr_last <= sel;
            pc_ctx  <= sel;
            pc_out  <= {pc_q[sel], 2'b00};
         end
      end
   end

endmodule
